// File: rtl/ps2_ascii_source.sv
// PS/2 keyboard receiver: synchronises the raw lines, frames 11-bit words and
// decodes set-2 make/break sequences into a held-key ASCII interface.
module ps2_ascii_source #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Ascii,
    output logic       clra,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [2:0]      clk_q;
    logic [2:0]      data_q;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bit;
    logic [TW-1:0]   to_cnt;
    logic            byte_done;
    logic [7:0]      rx_byte;
    logic            fall;
    logic            din;

    logic            break_flag;
    logic            ext_flag;
    logic [7:0]      held_code;
    logic [8:0]      mapped;

    // Stage 0 is the first (metastable) flop; an edge is seen between stages 1 and 2.
    assign fall = clk_q[2] & ~clk_q[1];
    assign din  = data_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q     <= 3'b111;
            data_q    <= 3'b111;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_done <= 1'b0;
            rx_byte   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            clk_q     <= {clk_q[1:0], ps2_clk};
            data_q    <= {data_q[1:0], ps2_data};
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!din) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= din;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (din && (^{shift, par_bit})) begin
                            byte_done <= 1'b1;
                            rx_byte   <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // {hit, ascii} for set-2 make codes; letters, digits and a few control keys.
    function automatic logic [8:0] map_code(input logic [7:0] c);
        case (c)
            8'h1C: map_code = {1'b1, 8'h61};
            8'h32: map_code = {1'b1, 8'h62};
            8'h21: map_code = {1'b1, 8'h63};
            8'h23: map_code = {1'b1, 8'h64};
            8'h24: map_code = {1'b1, 8'h65};
            8'h2B: map_code = {1'b1, 8'h66};
            8'h34: map_code = {1'b1, 8'h67};
            8'h33: map_code = {1'b1, 8'h68};
            8'h43: map_code = {1'b1, 8'h69};
            8'h3B: map_code = {1'b1, 8'h6A};
            8'h42: map_code = {1'b1, 8'h6B};
            8'h4B: map_code = {1'b1, 8'h6C};
            8'h3A: map_code = {1'b1, 8'h6D};
            8'h31: map_code = {1'b1, 8'h6E};
            8'h44: map_code = {1'b1, 8'h6F};
            8'h4D: map_code = {1'b1, 8'h70};
            8'h15: map_code = {1'b1, 8'h71};
            8'h2D: map_code = {1'b1, 8'h72};
            8'h1B: map_code = {1'b1, 8'h73};
            8'h2C: map_code = {1'b1, 8'h74};
            8'h3C: map_code = {1'b1, 8'h75};
            8'h2A: map_code = {1'b1, 8'h76};
            8'h1D: map_code = {1'b1, 8'h77};
            8'h22: map_code = {1'b1, 8'h78};
            8'h35: map_code = {1'b1, 8'h79};
            8'h1A: map_code = {1'b1, 8'h7A};
            8'h45: map_code = {1'b1, 8'h30};
            8'h16: map_code = {1'b1, 8'h31};
            8'h1E: map_code = {1'b1, 8'h32};
            8'h26: map_code = {1'b1, 8'h33};
            8'h25: map_code = {1'b1, 8'h34};
            8'h2E: map_code = {1'b1, 8'h35};
            8'h36: map_code = {1'b1, 8'h36};
            8'h3D: map_code = {1'b1, 8'h37};
            8'h3E: map_code = {1'b1, 8'h38};
            8'h46: map_code = {1'b1, 8'h39};
            8'h5A: map_code = {1'b1, 8'h0D};
            8'h29: map_code = {1'b1, 8'h20};
            8'h66: map_code = {1'b1, 8'h08};
            8'h76: map_code = {1'b1, 8'h1B};
            default: map_code = 9'h000;
        endcase
    endfunction

    assign mapped = map_code(rx_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            Ascii      <= 8'h00;
            clra       <= 1'b1;
            key_valid  <= 1'b0;
            scan_code  <= 8'h00;
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            held_code  <= 8'h00;
        end else begin
            key_valid <= 1'b0;
            if (byte_done) begin
                scan_code <= rx_byte;
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    break_flag <= 1'b1;
                end else if (ext_flag) begin
                    // Extended keys are not used by any consumer; swallow make and break.
                    ext_flag   <= 1'b0;
                    break_flag <= 1'b0;
                end else if (break_flag) begin
                    if (rx_byte == held_code) clra <= 1'b1;
                    break_flag <= 1'b0;
                end else if (mapped[8]) begin
                    Ascii     <= mapped[7:0];
                    held_code <= rx_byte;
                    clra      <= 1'b0;
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii_source.sv
// Directed bench for ps2_ascii_source: bit-banged PS/2 frames, with a queue of
// expected ASCII values popped on every key_valid pulse.
module tb_ps2_ascii_source;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] Ascii;
    logic       clra;
    logic       key_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int kv_count = 0;
    int fe_count = 0;
    logic [7:0] exp_q[$];

    ps2_ascii_source #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .Ascii(Ascii),
        .clra(clra),
        .key_valid(key_valid),
        .scan_code(scan_code),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err === 1'b1) fe_count++;
            if (key_valid === 1'b1) begin
                kv_count++;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL kv_unexpected observed=%0h expected=none", Ascii);
                end
                if (exp_q.size() != 0) chk("kv_ascii", {24'h0, Ascii}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clk(8);
        ps2_clk = 1'b0;
        wait_clk(15);
        ps2_clk = 1'b1;
        wait_clk(7);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ascii"}, {24'h0, Ascii}, 32'h00);
        chk({tag, "_clra"}, {31'h0, clra}, 32'h1);
        chk({tag, "_kv"}, {31'h0, key_valid}, 32'h0);
        chk({tag, "_scan"}, {24'h0, scan_code}, 32'h00);
        chk({tag, "_ferr"}, {31'h0, frame_err}, 32'h0);
    endtask

    initial begin
        logic [7:0] b1d;
        wait_clk(5);
        @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        wait_clk(5);

        // 1: make w
        exp_q.push_back(8'h77);
        send_key(8'h1D);
        @(negedge clk);
        chk("t1_ascii", {24'h0, Ascii}, 32'h77);
        chk("t1_clra", {31'h0, clra}, 32'h0);
        chk("t1_kv", kv_count, 1);
        chk("t1_scan", {24'h0, scan_code}, 32'h1D);

        // 2: break w, then Enter
        send_key(8'hF0);
        send_key(8'h1D);
        @(negedge clk);
        chk("t2_clra", {31'h0, clra}, 32'h1);
        chk("t2_ascii", {24'h0, Ascii}, 32'h77);
        chk("t2_kv", kv_count, 1);
        exp_q.push_back(8'h0D);
        send_key(8'h5A);
        @(negedge clk);
        chk("t2_enter", {24'h0, Ascii}, 32'h0D);
        chk("t2_clra2", {31'h0, clra}, 32'h0);

        // 3: parity error
        send_frame(8'h1B, 1'b1);
        @(negedge clk);
        chk("t3_fe", fe_count, 1);
        chk("t3_scan", {24'h0, scan_code}, 32'h5A);
        chk("t3_ascii", {24'h0, Ascii}, 32'h0D);
        chk("t3_clra", {31'h0, clra}, 32'h0);
        chk("t3_kv", kv_count, 2);

        // 4: partial frame then timeout
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TO + 10);
        @(negedge clk);
        chk("t4_fe", fe_count, 2);
        exp_q.push_back(8'h61);
        send_key(8'h1C);
        @(negedge clk);
        chk("t4_ascii", {24'h0, Ascii}, 32'h61);
        chk("t4_fe_once", fe_count, 2);
        // typematic repeat of held key
        exp_q.push_back(8'h61);
        send_key(8'h1C);
        @(negedge clk);
        chk("t4_repeat_kv", kv_count, 4);
        chk("t4_repeat_ascii", {24'h0, Ascii}, 32'h61);

        // 5: extended make/break ignored
        send_key(8'hE0);
        send_key(8'h75);
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        @(negedge clk);
        chk("t5_kv", kv_count, 4);
        chk("t5_clra", {31'h0, clra}, 32'h0);
        chk("t5_scan", {24'h0, scan_code}, 32'h75);
        chk("t5_ascii", {24'h0, Ascii}, 32'h61);

        // 6: overlapping keys
        exp_q.push_back(8'h77);
        send_key(8'h1D);
        exp_q.push_back(8'h73);
        send_key(8'h1B);
        send_key(8'hF0);
        send_key(8'h1D);
        @(negedge clk);
        chk("t6_ascii", {24'h0, Ascii}, 32'h73);
        chk("t6_clra_held", {31'h0, clra}, 32'h0);
        send_key(8'hF0);
        send_key(8'h1B);
        @(negedge clk);
        chk("t6_clra_rel", {31'h0, clra}, 32'h1);
        chk("t6_kv", kv_count, 6);

        // 7: reset during bit 5
        b1d = 8'h1D;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b1d[i]);
        ps2_data = b1d[4];
        wait_clk(8);
        ps2_clk = 1'b0;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check_reset("t7");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        exp_q.push_back(8'h77);
        send_key(8'h1D);
        @(negedge clk);
        chk("t7_ascii", {24'h0, Ascii}, 32'h77);
        chk("t7_clra", {31'h0, clra}, 32'h0);
        chk("t7_scan", {24'h0, scan_code}, 32'h1D);
        chk("t7_kv", kv_count, 7);
        chk("t7_fe", fe_count, 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
